// File: rtl/rsa_seq_ctrl.sv
// Sequencer for one modular exponentiation: runs rtMod (T, then R) and modInv (nprime0),
// streams the operands into ModExp word by word, then reads the result back.
module rsa_seq_ctrl #(
  parameter int WIDTH   = 4096,
  parameter int DW      = 64,
  parameter int WORDS   = WIDTH / DW,
  parameter int TIMEOUT = 2**20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             rt_go,
  output logic             rt_mode,
  output logic [WIDTH-1:0] rt_n,
  input  logic [WIDTH-1:0] rt_r,
  input  logic             rt_done,
  output logic             inv_go,
  input  logic [DW-1:0]    inv_val,
  input  logic             inv_valid,
  output logic [DW-1:0]    m_buf,
  output logic [DW-1:0]    e_buf,
  output logic [DW-1:0]    n_buf,
  output logic [DW-1:0]    r_buf,
  output logic [DW-1:0]    t_buf,
  output logic [DW-1:0]    nprime0,
  output logic             startInput,
  output logic             startCompute,
  output logic             getResult,
  input  logic [4:0]       exp_state,
  input  logic [DW-1:0]    res_out
);
  localparam int KW  = $clog2(WORDS + 1);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam int AW  = $clog2(WIDTH);
  localparam logic [4:0]     EXP_COMPLETE = 5'd9;
  localparam logic [WDW-1:0] WD_LAST      = WDW'(TIMEOUT - 1);
  localparam logic [KW-1:0]  K_LAST       = KW'(WORDS);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_T_GO         = 4'd1,
    S_T_WAIT       = 4'd2,
    S_R_GO         = 4'd3,
    S_R_WAIT       = 4'd4,
    S_N0_GO        = 4'd5,
    S_N0_WAIT      = 4'd6,
    S_LOAD         = 4'd7,
    S_COMPUTE_WAIT = 4'd8,
    S_READ         = 4'd9,
    S_FIN          = 4'd10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] m_r, e_r, n_r, t_r, r_r;
  logic [KW-1:0]    k_r;
  logic [WDW-1:0]   wd_r;
  logic [AW-1:0]    ld_base_s, rd_base_s;

  assign rt_n      = n_r;
  // READ cycle 0 is a latency cycle, so readback word k-1 lands on READ cycle k.
  assign ld_base_s = AW'(k_r) * AW'(DW);
  assign rd_base_s = AW'(k_r - KW'(1)) * AW'(DW);

  // Sequencer: state, word counter, watchdog, operand latches and every registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      m_r          <= '0;
      e_r          <= '0;
      n_r          <= '0;
      t_r          <= '0;
      r_r          <= '0;
      k_r          <= '0;
      wd_r         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      rt_go        <= 1'b0;
      rt_mode      <= 1'b0;
      inv_go       <= 1'b0;
      m_buf        <= '0;
      e_buf        <= '0;
      n_buf        <= '0;
      r_buf        <= '0;
      t_buf        <= '0;
      nprime0      <= '0;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
    end else begin
      rt_go  <= 1'b0;
      inv_go <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r     <= message;
            e_r     <= exponent;
            n_r     <= modulus;
            result  <= '0;
            err     <= 1'b0;
            nprime0 <= '0;
            k_r     <= '0;
            busy    <= 1'b1;
            state_r <= S_T_GO;
          end
        end
        S_T_GO: begin
          rt_go   <= 1'b1;
          rt_mode <= 1'b0;
          wd_r    <= '0;
          state_r <= S_T_WAIT;
        end
        S_T_WAIT: begin
          if (rt_done) begin
            t_r     <= rt_r;
            state_r <= S_R_GO;
          end else if (wd_r == WD_LAST) begin
            err     <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            state_r <= S_FIN;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        S_R_GO: begin
          rt_go   <= 1'b1;
          rt_mode <= 1'b1;
          wd_r    <= '0;
          state_r <= S_R_WAIT;
        end
        S_R_WAIT: begin
          if (rt_done) begin
            r_r     <= rt_r;
            state_r <= S_N0_GO;
          end else if (wd_r == WD_LAST) begin
            err     <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            state_r <= S_FIN;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        S_N0_GO: begin
          inv_go  <= 1'b1;
          wd_r    <= '0;
          state_r <= S_N0_WAIT;
        end
        S_N0_WAIT: begin
          if (inv_valid) begin
            nprime0    <= inv_val;
            startInput <= 1'b1;
            state_r    <= S_LOAD;
          end else if (wd_r == WD_LAST) begin
            err     <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            state_r <= S_FIN;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        S_LOAD: begin
          if (k_r == K_LAST) begin
            startCompute <= 1'b1;
            getResult    <= 1'b1;
            k_r          <= '0;
            wd_r         <= '0;
            state_r      <= S_COMPUTE_WAIT;
          end else begin
            m_buf <= m_r[ld_base_s +: DW];
            e_buf <= e_r[ld_base_s +: DW];
            n_buf <= n_r[ld_base_s +: DW];
            r_buf <= r_r[ld_base_s +: DW];
            t_buf <= t_r[ld_base_s +: DW];
            k_r   <= k_r + KW'(1);
          end
        end
        S_COMPUTE_WAIT: begin
          if (exp_state == EXP_COMPLETE) begin
            state_r <= S_READ;
          end else if (wd_r == WD_LAST) begin
            err          <= 1'b1;
            result       <= '0;
            done         <= 1'b1;
            startInput   <= 1'b0;
            startCompute <= 1'b0;
            getResult    <= 1'b0;
            state_r      <= S_FIN;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        S_READ: begin
          if (k_r != '0) begin
            result[rd_base_s +: DW] <= res_out;
          end
          if (k_r == K_LAST) begin
            k_r          <= '0;
            done         <= 1'b1;
            startInput   <= 1'b0;
            startCompute <= 1'b0;
            getResult    <= 1'b0;
            state_r      <= S_FIN;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rsa_seq_ctrl.md
# rsa_seq_ctrl

Synthesizable sequencer for one 4096-bit modular exponentiation. It replaces host-side sequencing of the RSA datapath. On a start pulse it runs, in order: `rtMod` mode 0 to produce T, `rtMod` mode 1 to produce R, and `modInv` to produce nprime0. It then streams the M/E/N/R/T words into `ModExp`, waits for completion, and reads the result back into a 4096-bit register.

## Interface
- `WIDTH`, 4096: operand width in bits.
- `DW`, 64: word width; equals `DATA_WIDTH`.
- `WORDS`, WIDTH/DW = 64: words per operand.
- `TIMEOUT`, 2^20: maximum cycles in any wait state.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Ignored unless in IDLE.
- `message`, `exponent`, `modulus` in WIDTH: operands, sampled only on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run, successful or timed out.
- `err` out 1: valid with `done`; 1 means timeout.
- `result` out WIDTH: ciphertext. Held until the next accepted `start`.
- `rt_go` out 1, `rt_mode` out 1, `rt_n` out WIDTH: to `rtMod`; `rt_n` is the latched modulus.
- `rt_r` in WIDTH, `rt_done` in 1: from `rtMod`.
- `inv_go` out 1: to `modInv`.
- `inv_val` in DW, `inv_valid` in 1: from `modInv`.
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf` out DW; `nprime0` out DW: to `ModExp`.
- `startInput`, `startCompute`, `getResult` out 1: to `ModExp`.
- `exp_state` in 5: from `ModExp`. COMPLETE = 9.
- `res_out` in DW: from `ModExp`.

## Operation
- Reset value of every output is 0, including `result`. Reset clears all internal registers and returns to IDLE. Reset mid-run aborts the run with no `done` pulse.
- States: IDLE → T_GO → T_WAIT → R_GO → R_WAIT → N0_GO → N0_WAIT → LOAD → COMPUTE_WAIT → READ → FIN → IDLE.
- IDLE: on `start`, latch message, exponent and modulus; clear `result`, `err` and the word counter.
- T_GO: `rt_go`=1 with `rt_mode`=0 for exactly one cycle → T_WAIT.
- T_WAIT: on `rt_done`, capture `rt_r` into the T register → R_GO.
- R_GO / R_WAIT: same as T_GO / T_WAIT with `rt_mode`=1; capture into the R register.
- `rt_mode` holds its value from the GO cycle through the end of the matching WAIT.
- N0_GO: `inv_go`=1 for one cycle → N0_WAIT.
- N0_WAIT: on `inv_valid`, capture `inv_val` into the `nprime0` output register (held until the next start) → LOAD.
- LOAD:
  - `startInput`=1 throughout.
  - Counter k runs 0..WORDS. For k<WORDS, drive each `*_buf` with operand[k*DW +: DW], LSW first; buffers are registered.
  - At k=WORDS, assert `startCompute`=1 and `getResult`=1, clear the counter, and go to COMPUTE_WAIT.
  - `startCompute` and `getResult` stay high until FIN.
- COMPUTE_WAIT: when `exp_state`==9, go to READ.
- READ:
  - Counter k runs 0..WORDS. Cycle k=0 is a latency cycle and `res_out` is discarded.
  - For k≥1, `result[(k-1)*DW +: DW]` ← `res_out`.
  - After k=WORDS → FIN.
- FIN: pulse `done`; deassert `startInput`, `startCompute` and `getResult` → IDLE.
- Timeout:
  - A watchdog counter clears on entry to each WAIT state and increments every cycle in it.
  - Reaching TIMEOUT-1 sets `err`, zeroes `result` and goes to FIN.
  - Counter width is clog2(TIMEOUT)+1.
- Simultaneous events:
  - `start` while busy is dropped, with no queueing.
  - `start` and `reset` in the same cycle: `reset` wins.
  - `rt_done` or `inv_valid` outside its WAIT state is ignored.

## Timing
- `rt_go` and `inv_go` are high exactly one cycle, on the cycle after entering their GO state.
- Capture latency: a response is registered on the edge where `rt_done` or `inv_valid` is seen. The next GO state follows one cycle later.
- LOAD lasts WORDS+1 = 65 cycles. Word k is on `*_buf` during LOAD cycle k+1.
- READ lasts WORDS+1 cycles. `done` rises the cycle after the last capture.
- Total overhead with zero-latency subordinates: 2+2+2+2+65+1+65+1 ≈ 140 cycles plus ModExp compute time.

## Test plan
- **End-to-end:** real `rtMod`/`modInv`/`ModExp`, message=8, exponent=13, modulus=77, `start` pulse → one `done`, `err`=0, `result`=50, `busy` low afterwards.
- **Stream ordering:**
  - Stubs: `rtMod` returns {64{64'hAAAA…}} for mode 0 and {64{64'h5555…}} for mode 1 after 3 cycles; `modInv` returns 64'h1234 after 5 cycles.
  - Scoreboard captures words during LOAD.
  - Pass: `t_buf` word k = AAAA…, `r_buf` word k = 5555…, `n_buf` word k = modulus[64k+:64], `nprime0` = 64'h1234.
- **Readback ordering:** `ModExp` stub sets `exp_state`=9, then drives `res_out`=k+100 on READ cycle k → `result` word j = j+101 for j=0..63.
- **Busy rejection:** second `start` pulsed during LOAD → ignored. Exactly one `done`, and latched operands unchanged in the stream.
- **Timeout:** TIMEOUT=64, `modInv` stub never asserts `inv_valid` → `done` with `err`=1 exactly 64 cycles after N0_WAIT entry. `result`=0; `startInput` never asserted.
- **Reset mid-run:** `reset` high one cycle at LOAD k=10 → next cycle all outputs 0, state IDLE, no `done`. A subsequent run with 8/13/77 gives `result`=50.
